// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared screen, colour and slot-state definitions.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;
    localparam int SCREEN_W       = 640;
    localparam int SCREEN_H       = 480;
    localparam int SHIP_Y_DEFAULT = 440;

    localparam logic [2:0] COLOR_BLACK = 3'b000;
    localparam logic [2:0] COLOR_WHITE = 3'b111;

    typedef logic [9:0] pos_t;

    typedef enum logic {
        SLOT_IDLE   = 1'b0,
        SLOT_FLYING = 1'b1
    } slot_state_e;
endpackage
`default_nettype wire

// File: rtl/laser_slot.sv
`default_nettype none
// ============================================================================
// Module      : laser_slot
// Description : One laser slot: IDLE/FLYING state, position and pixel compare.
// Revision    : 1.0 - initial release
// ============================================================================
module laser_slot
    import game_pkg::*;
#(
    parameter int SPEED      = 2,
    parameter int LASER_W    = 2,
    parameter int LASER_H    = 8,
    parameter int SHIP_Y     = SHIP_Y_DEFAULT,
    parameter int SCREEN_TOP = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       launch,
    input  logic       kill,
    input  logic [9:0] gun_x,
    input  logic [9:0] h_pos,
    input  logic [9:0] v_pos,
    output logic       flying,
    output logic       lit
);
    slot_state_e state_q, state_d;
    pos_t        x_q, x_d;
    pos_t        y_q, y_d;

    logic [10:0] x_e, y_e, h_e, v_e;

    // Kill beats step beats launch; a freshly launched slot does not move this cycle.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (kill) begin
            state_d = SLOT_IDLE;
        end else if (state_q == SLOT_FLYING) begin
            if (step) begin
                if ({1'b0, y_q} >= 11'(SCREEN_TOP + SPEED)) begin
                    y_d = y_q - 10'(SPEED);
                end else begin
                    state_d = SLOT_IDLE;
                end
            end
        end else if (launch) begin
            state_d = SLOT_FLYING;
            x_d     = gun_x;
            y_d     = 10'(SHIP_Y - LASER_H);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign x_e = {1'b0, x_q};
    assign y_e = {1'b0, y_q};
    assign h_e = {1'b0, h_pos};
    assign v_e = {1'b0, v_pos};

    assign flying = (state_q == SLOT_FLYING);
    assign lit    = flying
                  && (h_e >= x_e) && (h_e < x_e + 11'(LASER_W))
                  && (v_e >= y_e) && (v_e < y_e + 11'(LASER_H));
endmodule
`default_nettype wire

// File: rtl/laser_bank.sv
`default_nettype none
// ============================================================================
// Module      : laser_bank
// Description : Multi-shot laser engine; LASER_AUTOFIRE_EN makes fire level-driven.
// Revision    : 1.0 - initial release
// ============================================================================
module laser_bank
    import game_pkg::*;
#(
    parameter int         NUM_SHOTS  = 4,
    parameter int         SPEED      = 2,
    parameter int         COOLDOWN   = 16,
    parameter int         LASER_W    = 2,
    parameter int         LASER_H    = 8,
    parameter int         SHIP_Y     = SHIP_Y_DEFAULT,
    parameter int         SCREEN_TOP = 0,
    parameter logic [2:0] COLOR      = COLOR_WHITE,
    localparam int        SLOT_W     = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stepEnable,
    input  logic                 fire,
    input  logic [9:0]           gunPosition,
    input  logic [9:0]           hPos,
    input  logic [9:0]           vPos,
    input  logic                 killValid,
    input  logic [SLOT_W-1:0]    killSlot,
    output logic [2:0]           colorLaser,
    output logic                 pixelHit,
    output logic [SLOT_W-1:0]    pixelSlot,
    output logic [NUM_SHOTS-1:0] activeMask
);
    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic [NUM_SHOTS-1:0] flying, lit, kill_vec, free_vec, launch_vec;
    logic [SLOT_W-1:0]    free_idx;
    logic                 free_any, launch_req, launch_go;
    logic [CD_W-1:0]      cd_q, cd_d;
    logic                 fire_q;
    logic [2:0]           color_q, color_d;
    logic                 hit_q, hit_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;

`ifdef LASER_AUTOFIRE_EN
    assign launch_req = fire_q;
`else
    logic fire_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fire_prev_q <= 1'b0;
        else        fire_prev_q <= fire_q;
    end

    assign launch_req = fire_q & ~fire_prev_q;
`endif

    // A slot being killed this cycle is not offered as free until next cycle.
    always_comb begin
        kill_vec = killValid ? (NUM_SHOTS'(1) << killSlot) : '0;
        free_vec = ~flying & ~kill_vec;
        free_any = |free_vec;
        free_idx = '0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            if (free_vec[i]) free_idx = SLOT_W'(i);
        end
        launch_go  = launch_req && (cd_q == '0) && free_any;
        launch_vec = launch_go ? (NUM_SHOTS'(1) << free_idx) : '0;

        cd_d = cd_q;
        if (launch_go) begin
            cd_d = CD_W'(COOLDOWN);
        end else if (stepEnable && (cd_q != '0)) begin
            cd_d = cd_q - CD_W'(1);
        end
    end

    always_comb begin
        hit_d  = |lit;
        slot_d = '0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            if (lit[i]) slot_d = SLOT_W'(i);
        end
        color_d = hit_d ? COLOR : COLOR_BLACK;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fire_q  <= 1'b0;
            cd_q    <= '0;
            color_q <= COLOR_BLACK;
            hit_q   <= 1'b0;
            slot_q  <= '0;
        end else begin
            fire_q  <= fire;
            cd_q    <= cd_d;
            color_q <= color_d;
            hit_q   <= hit_d;
            slot_q  <= slot_d;
        end
    end

    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
        laser_slot #(
            .SPEED      (SPEED),
            .LASER_W    (LASER_W),
            .LASER_H    (LASER_H),
            .SHIP_Y     (SHIP_Y),
            .SCREEN_TOP (SCREEN_TOP)
        ) u_slot (
            .clk    (clk),
            .rst_n  (reset),
            .step   (stepEnable),
            .launch (launch_vec[g]),
            .kill   (kill_vec[g]),
            .gun_x  (gunPosition),
            .h_pos  (hPos),
            .v_pos  (vPos),
            .flying (flying[g]),
            .lit    (lit[g])
        );
    end

    assign colorLaser = color_q;
    assign pixelHit   = hit_q;
    assign pixelSlot  = slot_q;
    assign activeMask = flying;
endmodule
`default_nettype wire

// File: tb/tb_laser_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_laser_bank
// Description : Directed self-checking bench for laser_bank with a slot-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_laser_bank;
    localparam int NS      = 4;
    localparam int SPD     = 2;
    localparam int CD      = 16;
    localparam int LW      = 2;
    localparam int LH      = 8;
    localparam int SHIPY   = 440;
    localparam int TOP     = 0;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       stepEnable, fire, killValid;
    logic [9:0] gunPosition, hPos, vPos;
    logic [1:0] killSlot;
    logic [2:0] colorLaser;
    logic       pixelHit;
    logic [1:0] pixelSlot;
    logic [3:0] activeMask;

    int checks = 0;
    int errors = 0;

    // Model state: current and next values of each slot, cooldown and fire history.
    bit m_fly[NS];
    int m_x[NS], m_y[NS];
    bit n_fly[NS];
    int n_x[NS], n_y[NS];
    int m_cd, n_cd;
    bit m_fq, m_fp, n_fq, n_fp;
    int e_hit, e_slot;

    laser_bank #(
        .NUM_SHOTS(NS), .SPEED(SPD), .COOLDOWN(CD), .LASER_W(LW), .LASER_H(LH),
        .SHIP_Y(SHIPY), .SCREEN_TOP(TOP), .COLOR(3'b111)
    ) dut (
        .clk(clk), .reset(reset_n), .stepEnable(stepEnable), .fire(fire),
        .gunPosition(gunPosition), .hPos(hPos), .vPos(vPos),
        .killValid(killValid), .killSlot(killSlot),
        .colorLaser(colorLaser), .pixelHit(pixelHit), .pixelSlot(pixelSlot),
        .activeMask(activeMask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_mask();
        int m = 0;
        for (int i = 0; i < NS; i++) if (m_fly[i]) m |= (1 << i);
        return m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin
            m_fly[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_cd = 0; m_fq = 0; m_fp = 0; e_hit = 0; e_slot = 0;
    endtask

    task automatic model_next();
        int  sel;
        bit  req;
        e_hit = 0;
        e_slot = 0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (m_fly[i] && int'(hPos) >= m_x[i] && int'(hPos) < m_x[i] + LW &&
                int'(vPos) >= m_y[i] && int'(vPos) < m_y[i] + LH) begin
                e_hit = 1;
                e_slot = i;
            end
        end
        for (int i = 0; i < NS; i++) begin
            n_fly[i] = m_fly[i]; n_x[i] = m_x[i]; n_y[i] = m_y[i];
            if (killValid && int'(killSlot) == i) n_fly[i] = 0;
            else if (m_fly[i] && stepEnable) begin
                if (m_y[i] >= TOP + SPD) n_y[i] = m_y[i] - SPD;
                else n_fly[i] = 0;
            end
        end
        sel = -1;
        for (int i = 0; i < NS; i++)
            if (sel < 0 && !m_fly[i] && !(killValid && int'(killSlot) == i)) sel = i;
`ifdef LASER_AUTOFIRE_EN
        req = m_fq;
`else
        req = m_fq && !m_fp;
`endif
        n_cd = (stepEnable && m_cd > 0) ? m_cd - 1 : m_cd;
        if (req && m_cd == 0 && sel >= 0) begin
            n_fly[sel] = 1;
            n_x[sel] = int'(gunPosition);
            n_y[sel] = SHIPY - LH;
            n_cd = CD;
        end
        n_fq = fire;
        n_fp = m_fq;
        if (!reset_n) begin
            for (int i = 0; i < NS; i++) begin
                n_fly[i] = 0; n_x[i] = 0; n_y[i] = 0;
            end
            n_cd = 0; n_fq = 0; n_fp = 0; e_hit = 0; e_slot = 0;
        end
    endtask

    // One clock: evaluate model from settled inputs, commit at the edge, compare at negedge.
    task automatic tick();
        model_next();
        @(posedge clk);
        m_fly = n_fly; m_x = n_x; m_y = n_y;
        m_cd = n_cd; m_fq = n_fq; m_fp = n_fp;
        @(negedge clk);
        chk("activeMask", int'(activeMask), model_mask());
        chk("pixelHit", int'(pixelHit), e_hit);
        chk("pixelSlot", int'(pixelSlot), e_slot);
        chk("colorLaser", int'(colorLaser), e_hit ? 7 : 0);
    endtask

    task automatic step_n(input int n);
        for (int k = 0; k < n; k++) begin
            stepEnable = 1'b1; tick();
            stepEnable = 1'b0; tick();
        end
    endtask

    task automatic fire_edge();
        fire = 1'b1; tick();
        fire = 1'b0; tick();
    endtask

    task automatic kill(input int s);
        killValid = 1'b1; killSlot = 2'(s); tick();
        killValid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; stepEnable = 1'b0; fire = 1'b0; killValid = 1'b0;
        killSlot = 2'd0; gunPosition = 10'd300; hPos = 10'd0; vPos = 10'd0;
        model_clear();
        tick(); tick();
        chk("reset_mask", int'(activeMask), 0);
        chk("reset_color", int'(colorLaser), 0);
        chk("reset_hit", int'(pixelHit), 0);
        chk("reset_slot", int'(pixelSlot), 0);
        reset_n = 1'b1;
        tick();

        // Single shot: launch visible two edges after fire rises.
        fire = 1'b1; tick();
        chk("launch_latency_n1", int'(activeMask), 0);
        fire = 1'b0; tick();
        chk("launch_latency_n2", int'(activeMask), 1);
        chk("model_x0", m_x[0], 300);
        chk("model_y0", m_y[0], 432);
        step_n(10);
        chk("model_y_10steps", m_y[0], 412);
        hPos = 10'd301; vPos = 10'd415; tick();
        chk("pix_301_415_color", int'(colorLaser), 7);
        hPos = 10'd302; tick();
        chk("pix_right_edge", int'(pixelHit), 0);
        hPos = 10'd300; vPos = 10'd419; tick();
        chk("pix_bottom_in", int'(pixelHit), 1);
        vPos = 10'd420; tick();
        chk("pix_bottom_out", int'(pixelHit), 0);

        // Exit off the top: y reaches 0 after 216 steps, retires on the 217th.
        step_n(206);
        chk("model_y_top", m_y[0], 0);
        chk("mask_at_top", int'(activeMask), 1);
        vPos = 10'd0; tick();
        chk("pix_at_row0", int'(pixelHit), 1);
        step_n(1);
        chk("mask_after_exit", int'(activeMask), 0);

        // Bank full: four launches fill the bank, the fifth edge is dropped.
        hPos = 10'd100; vPos = 10'd300;
        for (int k = 0; k < 4; k++) begin
            gunPosition = 10'(100 + 40 * k);
            fire_edge();
            step_n(20);
        end
        chk("bank_full", int'(activeMask), 15);
        fire_edge();
        chk("fifth_dropped", int'(activeMask), 15);
        step_n(20);
        kill(2);
        chk("kill_slot2", int'(activeMask), 4'b1011);
        fire_edge();
        chk("relaunch_slot2", int'(activeMask), 15);
        step_n(5);
        kill(0);
        chk("kill_slot0", int'(activeMask), 4'b1110);
        fire_edge();
        chk("cooldown_drop", int'(activeMask), 4'b1110);
        step_n(11);
        fire_edge();
        chk("after_cooldown", int'(activeMask), 15);
        step_n(16);

        // Kill, step and a launch request in the same clock on the same slot.
        fire = 1'b1; tick();
        killValid = 1'b1; killSlot = 2'd1; stepEnable = 1'b1; tick();
        killValid = 1'b0; stepEnable = 1'b0;
        chk("kill_priority", int'(activeMask), 4'b1101);
        fire = 1'b0; tick();
        fire_edge();
        chk("relaunch_slot1", int'(activeMask), 15);

        // Reset mid-flight with three slots flying and fire held.
        kill(3);
        chk("three_flying", int'(activeMask), 4'b0111);
        fire = 1'b1; tick();
        #2 reset_n = 1'b0;
        model_clear();
        #1;
        chk("async_reset_mask", int'(activeMask), 0);
        chk("async_reset_color", int'(colorLaser), 0);
        @(negedge clk);
        tick();
        reset_n = 1'b1; tick();
        chk("no_launch_after_release", int'(activeMask), 0);
        tick();
        chk("launch_after_release", int'(activeMask), 1);

        // Fire held for 100 steps.
        step_n(100);
`ifdef LASER_AUTOFIRE_EN
        chk("held_fire_launches", int'(activeMask), 15);
`else
        chk("held_fire_launches", int'(activeMask), 1);
`endif
        fire = 1'b0; tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/laser_bank.md
# laser_bank

Multi-shot player laser engine for the Space Invaders game. It replaces the single-shot laser with a parametrised bank of independent laser slots, a fire cooldown and per-slot kill handling. It sits between the button/spaceship logic (fire, gunPosition), the VGA scan counters (hPos, vPos) and the alien collision logic. Its colour output feeds the colour-sum stage ahead of the final colour block.

## Interface
Parameters:
- NUM_SHOTS, 4: number of simultaneous laser slots (1..8).
- SPEED, 2: pixels moved upward per step.
- COOLDOWN, 16: steps between successive launches.
- LASER_W, 2: laser width in pixels.
- LASER_H, 8: laser height in pixels.
- SHIP_Y, 440: top row of the spaceship; launch row is SHIP_Y-LASER_H.
- SCREEN_TOP, 0: topmost visible row.
- COLOR, 3'b111: laser colour.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- stepEnable  in  1  one-clk movement tick from the laser TimeUnitEnable.
- fire  in  1  fire button level, already debounced.
- gunPosition  in  10  x of the gun's left edge.
- hPos  in  10  current VGA column.
- vPos  in  10  current VGA row.
- killValid  in  1  collision logic reports that a slot hit an alien.
- killSlot  in  $clog2(NUM_SHOTS)  slot index to retire.
- colorLaser  out  3  COLOR when the current pixel is lit, else 0.
- pixelHit  out  1  current pixel belongs to an active laser.
- pixelSlot  out  $clog2(NUM_SHOTS)  lowest-index slot lit at this pixel.
- activeMask  out  NUM_SHOTS  per-slot flying flag.

## Operation
- Each slot has a 2-state FSM:
  - IDLE: position is don't-care.
  - FLYING: holds x[9:0] and y[9:0].
- Fire detection:
  - fire is registered once.
  - A launch request is the rising edge (fire=1, previous=0).
- Launch conditions: request present, cooldown counter = 0, and at least one IDLE slot (free mask taken from registered state).
- Launch action:
  - The lowest-index IDLE slot loads x=gunPosition, y=SHIP_Y-LASER_H and enters FLYING.
  - The cooldown counter loads COOLDOWN.
- Requests that fail any launch condition are dropped, not queued. A dropped request does not load the cooldown.
- On stepEnable:
  - Each FLYING slot with y >= SCREEN_TOP+SPEED does y <= y-SPEED.
  - Each FLYING slot with y < SCREEN_TOP+SPEED goes to IDLE. This is an exit off the top; y never wraps.
  - A nonzero cooldown decrements by 1.
- killValid retires slot killSlot to IDLE. A kill on an IDLE slot has no effect.
- Priority within one clk for the same slot: kill > step > launch.
  - A slot killed this cycle is not launchable until the next cycle.
  - A launch and a step in the same cycle: the new slot takes no step that cycle.
- Rendering:
  - A pixel is lit when any FLYING slot has x <= hPos < x+LASER_W and y <= vPos < y+LASER_H.
  - Comparisons use 11-bit arithmetic so x+LASER_W does not overflow.
  - pixelSlot is the lowest lit index, and 0 when nothing is lit.

## Timing
- Reset values:
  - All slots IDLE, cooldown 0, fire register 0.
  - colorLaser=0, pixelHit=0, pixelSlot=0, activeMask=0.
- Reset mid-flight clears all slots immediately; no launch occurs on the first clk after release.
- Launch: fire rises at edge N; the slot is FLYING and visible in activeMask after edge N+2 (register plus launch).
- Render latency:
  - colorLaser, pixelHit and pixelSlot are registered, lagging (hPos, vPos) by exactly 1 clk.
  - The downstream colour sum compensates for this lag.
- A kill takes effect at the next edge. The pixel outputs reflect it 1 clk later.
- Movement occurs only on stepEnable cycles. Between ticks, state is static except for launch and kill.

## Configuration
- LASER_AUTOFIRE_EN defined: a launch request is fire level high. Holding fire launches every COOLDOWN steps while a free slot exists.
- LASER_AUTOFIRE_EN undefined: rising edge only. Holding fire yields exactly one launch.

## Structure
- Shared package game_pkg holds:
  - screen constants (640x480, SHIP_Y default);
  - colour constants (COLOR_BLACK, COLOR_WHITE);
  - typedef pos_t = logic [9:0].
- Sub-module laser_slot holds one slot's FSM, position registers and pixel compare. It outputs flying and lit.
- laser_bank instantiates NUM_SHOTS laser_slots with a generate loop. It adds the fire edge detect, the cooldown counter, the lowest-free priority encoder and the lowest-lit encoder.

## Test plan
- Single shot:
  - Setup: reset, gunPosition=300, one fire pulse.
  - Expected: slot0 FLYING at x=300, y=432. After 10 steps y=412. Pixel (301,415) gives colorLaser=7 one clk later.
- Exit top: slot launched at y=432 with SPEED=2 returns to IDLE on the 217th step (y reached 0), with no wrap to 1023.
- Bank full and cooldown:
  - Stimulus: 5 fire edges spaced 20 steps apart.
  - Expected: slots 0..3 launch and the 5th edge is dropped (activeMask=4'b1111).
  - Stimulus: an edge 5 steps after a launch.
  - Expected: dropped by cooldown.
- Kill priority: killValid with killSlot=1 in the same clk as stepEnable and a fire edge. Expected: slot1 IDLE, not relaunched that clk; the launch takes slot1 on the next qualifying request.
- Reset mid-flight: assert reset with 3 slots flying. Expected: activeMask=0 and colorLaser=0 asynchronously, and no launch on the first clk after release.
- Autofire: with LASER_AUTOFIRE_EN, fire held 100 steps gives launches at steps 0, 16, 32, 48, then none until a slot frees. Without the macro: one launch.
